// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and byte-lane helpers for the SRAM controller.
// The optional alignment-error response is selected with AHBL_SRAM_ALIGN_ERR_EN.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } err_state_e;

    // Unaligned offsets are masked down to alignment; oversize transfers count as words.
    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << off;
            HSIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] rdata, input logic [31:0] wdata,
                                          input logic [3:0] mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = mask[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ahbl_sram_wbuf.sv
// One-entry posted write buffer: holds a word address, byte mask and data,
// and overlays its bytes onto SRAM read data when a read hits the same word.
module ahbl_sram_wbuf
    import ahbl_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [3:0]    load_mask_i,
    input  logic [31:0]   load_data_i,
    input  logic          commit_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [31:0]   rdata_i,
    output logic          vld_o,
    output logic [AW-1:0] addr_o,
    output logic [3:0]    mask_o,
    output logic [31:0]   data_o,
    output logic [31:0]   fwd_o
);

    logic          vld_q, vld_d;
    logic [AW-1:0] addr_q;
    logic [3:0]    mask_q;
    logic [31:0]   data_q;
    logic          hit;

    // A reload on the committing edge keeps the entry valid.
    always_comb begin
        vld_d = vld_q;
        if (commit_i) vld_d = 1'b0;
        if (load_i)   vld_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) vld_q <= 1'b0;
        else       vld_q <= vld_d;
    end

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            addr_q <= load_addr_i;
            mask_q <= load_mask_i;
            data_q <= load_data_i;
        end
    end

    assign hit    = vld_q && (addr_q == rd_addr_i);
    assign fwd_o  = merge(rdata_i, data_q, hit ? mask_q : 4'b0000);
    assign vld_o  = vld_q;
    assign addr_o = addr_q;
    assign mask_o = mask_q;
    assign data_o = data_q;

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite slave in front of a 1-cycle synchronous SRAM with zero wait states.
// Define AHBL_SRAM_ALIGN_ERR_EN to answer unaligned/oversize transfers with ERROR.
module ahbl_sram_ctrl
    import ahbl_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    logic          acc, bad, ok_acc, rd_issue, wr_ap, wr_dp;
    logic [AW-1:0] ap_addr;
    logic [3:0]    ap_mask;
    logic          dp_wr_q, dp_wr_d, dp_rd_q, dp_rd_d;
    logic [AW-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]    dp_mask_q, dp_mask_d;
    logic          buf_vld, buf_load, buf_commit;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_mask;
    logic [31:0]   buf_data, fwd_data;
    logic          unused_bits;

    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign acc     = HSEL & HTRANS[1] & HREADY;
    assign ap_addr = HADDR[AW+1:2];
    assign ap_mask = byte_mask(HSIZE, HADDR[1:0]);

`ifdef AHBL_SRAM_ALIGN_ERR_EN
    err_state_e state_q, state_d;

    assign bad = (HSIZE > HSIZE_WORD)
               | ((HSIZE == HSIZE_HALF) & HADDR[0])
               | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_IDLE: if (acc && bad) state_d = ST_ERR1;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = HRESP_ERROR;
                state_d = (acc && bad) ? ST_ERR1 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
`else
    assign bad       = 1'b0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = HRESP_OKAY;
`endif

    assign ok_acc   = acc & ~bad;
    assign rd_issue = ok_acc & ~HWRITE;
    assign wr_ap    = ok_acc & HWRITE;
    assign wr_dp    = dp_wr_q & HREADY;

    always_comb begin
        dp_wr_d   = dp_wr_q;
        dp_rd_d   = dp_rd_q;
        dp_addr_d = dp_addr_q;
        dp_mask_d = dp_mask_q;
        if (HREADY) begin
            dp_wr_d = wr_ap;
            dp_rd_d = rd_issue;
            if (ok_acc) begin
                dp_addr_d = ap_addr;
                dp_mask_d = ap_mask;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_wr_q   <= 1'b0;
            dp_rd_q   <= 1'b0;
            dp_addr_q <= '0;
            dp_mask_q <= '0;
        end else begin
            dp_wr_q   <= dp_wr_d;
            dp_rd_q   <= dp_rd_d;
            dp_addr_q <= dp_addr_d;
            dp_mask_q <= dp_mask_d;
        end
    end

    // Port priority: read, then buffered write, then a data-phase write straight
    // from HWDATA. Writing through when the buffer is empty keeps it free for the
    // next write whose data phase may overlap a read address phase.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = ap_addr;
        sram_wdata = buf_data;
        buf_commit = 1'b0;
        buf_load   = 1'b0;
        if (!HRESET) begin
            if (rd_issue) begin
                sram_en  = 1'b1;
                buf_load = wr_dp;
            end else if (buf_vld) begin
                sram_en    = 1'b1;
                sram_we    = buf_mask;
                sram_addr  = buf_addr;
                buf_commit = 1'b1;
                buf_load   = wr_dp;
            end else if (wr_dp) begin
                sram_en    = 1'b1;
                sram_we    = dp_mask_q;
                sram_addr  = dp_addr_q;
                sram_wdata = HWDATA;
            end
        end
    end

    ahbl_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk_i       (HCLK),
        .rst_i       (HRESET),
        .load_i      (buf_load),
        .load_addr_i (dp_addr_q),
        .load_mask_i (dp_mask_q),
        .load_data_i (HWDATA),
        .commit_i    (buf_commit),
        .rd_addr_i   (dp_addr_q),
        .rdata_i     (sram_rdata),
        .vld_o       (buf_vld),
        .addr_o      (buf_addr),
        .mask_o      (buf_mask),
        .data_o      (buf_data),
        .fwd_o       (fwd_data)
    );

    assign HRDATA = dp_rd_q ? fwd_data : 32'h0;

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// Directed bench for ahbl_sram_ctrl with a behavioural 1-cycle SRAM model.
// Works in both builds; the alignment test follows AHBL_SRAM_ALIGN_ERR_EN.
module tb_ahbl_sram_ctrl;
    import ahbl_pkg::*;

    localparam int AW = 10;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    logic [31:0] mem [0:(1<<AW)-1];
    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT;

    always @(posedge HCLK) begin
        if (sram_en) begin
            for (int i = 0; i < 4; i++)
                if (sram_we[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            sram_rdata <= mem[sram_addr];
        end
    end

    ahbl_sram_ctrl #(.AW(AW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // One bus cycle: address-phase signals plus HWDATA for the previous transfer;
    // returns at the falling edge so outputs of that cycle can be sampled.
    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic [2:0] size, input logic wr, input logic [31:0] wdata);
        @(posedge HCLK);
        #1;
        HSEL   = sel;
        HTRANS = trans;
        HADDR  = addr;
        HSIZE  = size;
        HWRITE = wr;
        HWDATA = wdata;
        @(negedge HCLK);
    endtask

    task automatic idle(input logic [31:0] wdata);
        drive(1'b1, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, wdata);
    endtask

    task automatic test_reset;
        HRESET = 1'b1;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h10; HSIZE = HSIZE_WORD;
        HWRITE = 1'b0; HWDATA = 32'h0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        tests++; if (HREADYOUT !== 1'b1) begin fails++; $display("FAIL rst_hreadyout got %b exp 1", HREADYOUT); end
        tests++; if (HRESP !== 1'b0) begin fails++; $display("FAIL rst_hresp got %b exp 0", HRESP); end
        tests++; if (HRDATA !== 32'h0) begin fails++; $display("FAIL rst_hrdata got %h exp 0", HRDATA); end
        tests++; if (sram_en !== 1'b0) begin fails++; $display("FAIL rst_sram_en got %b exp 0", sram_en); end
        tests++; if (sram_we !== 4'h0) begin fails++; $display("FAIL rst_sram_we got %h exp 0", sram_we); end
        @(posedge HCLK);
        #1;
        HTRANS = HTRANS_IDLE;
        HRESET = 1'b0;
    endtask

    task automatic test_word_write_read;
        drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1, 32'h0);
        idle(32'hDEADBEEF);
        drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0, 32'h0);
        tests++; if (sram_en !== 1'b1 || sram_we !== 4'h0 || sram_addr !== 10'd4) begin
            fails++; $display("FAIL wr_rd_strobe got en=%b we=%h addr=%0d exp en=1 we=0 addr=4", sram_en, sram_we, sram_addr); end
        idle(32'h0);
        tests++; if (HRDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rd_hrdata got %h exp deadbeef", HRDATA); end
        tests++; if (HREADYOUT !== 1'b1) begin fails++; $display("FAIL wr_rd_hreadyout got %b exp 1", HREADYOUT); end
        tests++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rd_mem4 got %h exp deadbeef", mem[4]); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b1, 32'h0);
        drive(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0, 32'h11223344);
        tests++; if (sram_en !== 1'b1 || sram_we !== 4'h0 || sram_addr !== 10'd8) begin
            fails++; $display("FAIL b2b_read_strobe got en=%b we=%h addr=%0d exp en=1 we=0 addr=8", sram_en, sram_we, sram_addr); end
        idle(32'h0);
        tests++; if (HRDATA !== 32'h11223344) begin fails++; $display("FAIL b2b_forward got %h exp 11223344", HRDATA); end
        tests++; if (sram_en !== 1'b1 || sram_we !== 4'hF || sram_addr !== 10'd8 || sram_wdata !== 32'h11223344) begin
            fails++; $display("FAIL b2b_commit got en=%b we=%h addr=%0d wd=%h exp en=1 we=f addr=8 wd=11223344",
                              sram_en, sram_we, sram_addr, sram_wdata); end
        idle(32'h0);
        tests++; if (mem[8] !== 32'h11223344) begin fails++; $display("FAIL b2b_mem8 got %h exp 11223344", mem[8]); end
    endtask

    task automatic test_byte_merge;
        drive(1'b1, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 1'b1, 32'h0);
        idle(32'hAABBCCDD);
        idle(32'h0);
        drive(1'b1, HTRANS_NONSEQ, 32'h1, HSIZE_BYTE, 1'b1, 32'h0);
        drive(1'b1, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 1'b0, 32'h0000EE00);
        idle(32'h0);
        tests++; if (HRDATA !== 32'hAABBEEDD) begin fails++; $display("FAIL merge_hrdata got %h exp aabbeedd", HRDATA); end
        tests++; if (sram_we !== 4'b0010) begin fails++; $display("FAIL merge_commit_we got %b exp 0010", sram_we); end
        idle(32'h0);
        tests++; if (mem[0] !== 32'hAABBEEDD) begin fails++; $display("FAIL merge_mem0 got %h exp aabbeedd", mem[0]); end
    endtask

    task automatic test_stream;
        drive(1'b1, HTRANS_NONSEQ, 32'h4, HSIZE_WORD, 1'b1, 32'h0);
        drive(1'b1, HTRANS_NONSEQ, 32'h8, HSIZE_WORD, 1'b1, 32'h04040404);
        idle(32'h08080808);
        idle(32'h0);
        drive(1'b1, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 1'b1, 32'h0);
        drive(1'b1, HTRANS_SEQ,    32'h4, HSIZE_WORD, 1'b0, 32'hA0A0A0A0);
        tests++; if (sram_addr !== 10'd1 || sram_we !== 4'h0) begin
            fails++; $display("FAIL stream_rd4 got addr=%0d we=%h exp addr=1 we=0", sram_addr, sram_we); end
        drive(1'b1, HTRANS_SEQ,    32'h8, HSIZE_WORD, 1'b0, 32'h0);
        tests++; if (HRDATA !== 32'h04040404) begin fails++; $display("FAIL stream_hrdata4 got %h exp 04040404", HRDATA); end
        drive(1'b1, HTRANS_SEQ,    32'hC, HSIZE_WORD, 1'b1, 32'h0);
        tests++; if (HRDATA !== 32'h08080808) begin fails++; $display("FAIL stream_hrdata8 got %h exp 08080808", HRDATA); end
        tests++; if (sram_we !== 4'hF || sram_addr !== 10'd0) begin
            fails++; $display("FAIL stream_commit got we=%h addr=%0d exp we=f addr=0", sram_we, sram_addr); end
        idle(32'hC0C0C0C0);
        tests++; if (HREADYOUT !== 1'b1) begin fails++; $display("FAIL stream_hreadyout got %b exp 1", HREADYOUT); end
        idle(32'h0);
        tests++; if (mem[0] !== 32'hA0A0A0A0 || mem[3] !== 32'hC0C0C0C0 || mem[1] !== 32'h04040404 || mem[2] !== 32'h08080808) begin
            fails++; $display("FAIL stream_mem got %h %h %h %h exp a0a0a0a0 04040404 08080808 c0c0c0c0",
                              mem[0], mem[1], mem[2], mem[3]); end
    endtask

    task automatic test_reset_data_phase;
        drive(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b1, 32'h0);
        idle(32'h12345678);
        idle(32'h0);
        drive(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_BYTE, 1'b1, 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        HTRANS = HTRANS_IDLE;
        HWDATA = 32'h00000055;
        @(negedge HCLK);
        tests++; if (sram_en !== 1'b0) begin fails++; $display("FAIL rstdp_sram_en got %b exp 0", sram_en); end
        tests++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
            fails++; $display("FAIL rstdp_resp got hresp=%b hreadyout=%b exp 0 1", HRESP, HREADYOUT); end
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        idle(32'h0);
        idle(32'h0);
        tests++; if (mem[12] !== 32'h12345678) begin fails++; $display("FAIL rstdp_mem12 got %h exp 12345678", mem[12]); end
    endtask

    task automatic test_align;
`ifdef AHBL_SRAM_ALIGN_ERR_EN
        drive(1'b1, HTRANS_NONSEQ, 32'h3, HSIZE_HALF, 1'b0, 32'h0);
        tests++; if (sram_en !== 1'b0) begin fails++; $display("FAIL align_sram_en got %b exp 0", sram_en); end
        idle(32'h0);
        tests++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin
            fails++; $display("FAIL align_err1 got hreadyout=%b hresp=%b exp 0 1", HREADYOUT, HRESP); end
        idle(32'h0);
        tests++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin
            fails++; $display("FAIL align_err2 got hreadyout=%b hresp=%b exp 1 1", HREADYOUT, HRESP); end
        idle(32'h0);
        tests++; if (HRESP !== 1'b0) begin fails++; $display("FAIL align_done got hresp=%b exp 0", HRESP); end
`else
        drive(1'b1, HTRANS_NONSEQ, 32'h3, HSIZE_HALF, 1'b1, 32'h0);
        drive(1'b1, HTRANS_NONSEQ, 32'h3, HSIZE_HALF, 1'b0, 32'h77660000);
        tests++; if (sram_en !== 1'b1 || sram_we !== 4'h0 || sram_addr !== 10'd0) begin
            fails++; $display("FAIL align_rd_strobe got en=%b we=%h addr=%0d exp en=1 we=0 addr=0", sram_en, sram_we, sram_addr); end
        idle(32'h0);
        tests++; if (HRDATA !== 32'h7766A0A0 || HRESP !== 1'b0) begin
            fails++; $display("FAIL align_hrdata got %h hresp=%b exp 7766a0a0 0", HRDATA, HRESP); end
        idle(32'h0);
        tests++; if (mem[0] !== 32'h7766A0A0) begin fails++; $display("FAIL align_mem0 got %h exp 7766a0a0", mem[0]); end
`endif
    endtask

    task automatic test_alias_and_noacc;
        drive(1'b1, HTRANS_NONSEQ, 32'h1010, HSIZE_WORD, 1'b0, 32'h0);
        tests++; if (sram_addr !== 10'd4) begin fails++; $display("FAIL alias_addr got %0d exp 4", sram_addr); end
        drive(1'b0, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0, 32'h0);
        tests++; if (HRDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL alias_hrdata got %h exp deadbeef", HRDATA); end
        tests++; if (sram_en !== 1'b0) begin fails++; $display("FAIL unsel_sram_en got %b exp 0", sram_en); end
        drive(1'b1, HTRANS_BUSY, 32'h20, HSIZE_WORD, 1'b0, 32'h0);
        tests++; if (sram_en !== 1'b0 || HRESP !== 1'b0) begin
            fails++; $display("FAIL busy_noacc got en=%b hresp=%b exp 0 0", sram_en, HRESP); end
        idle(32'h0);
    endtask

    initial begin
        test_reset();
        test_word_write_read();
        test_back_to_back();
        test_byte_merge();
        test_stream();
        test_reset_data_phase();
        test_align();
        test_alias_and_noacc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
